alu_arbiter: RTL

Two-port arbiter sharing the single 16-bit ALU between two requesters, e.g. the main execute path (port 0) and an address/branch-compare unit (port 1). It accepts operations over a valid/ready handshake, drives the ALU operand and control inputs for the granted port, and captures the ALU result and zero flag into a per-port response register with back-pressure. Port choice is round-robin by default. Op codes the ALU does not define are answered locally with an error flag.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_rr_pick.sv | 25 ++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants and the defined-op test used by
// the ALU arbiter. ALU_IDLE_OP is what the ALU sees when nobody is granted.
package alu_pkg;

    localparam logic [2:0] ALU_AND     = 3'b000;
    localparam logic [2:0] ALU_OR      = 3'b001;
    localparam logic [2:0] ALU_ADD     = 3'b010;
    localparam logic [2:0] ALU_SUB     = 3'b110;
    localparam logic [2:0] ALU_SLT     = 3'b111;
    localparam logic [2:0] ALU_IDLE_OP = ALU_ADD;

    // True for op codes the ALU implements; 011, 100 and 101 are undefined.
    function automatic logic aluOpValid(input logic [2:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: aluOpValid = 1'b1;
            default:                                    aluOpValid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way grant picker for the ALU arbiter.
// Default: round-robin, the port that did not win last time takes a tie.
// ALU_ARB_FIXED_PRIO_EN: port 0 always takes a tie and lastGrant is ignored.
module alu_rr_pick
    import alu_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       lastGrant,
    output logic [1:0] grantVec,
    output logic       grantId
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: lastGrant has no influence.
    logic unused_last_grant;
    assign unused_last_grant = lastGrant;
    assign grantId = eligible[1] & ~eligible[0];
`else
    // Port 1 wins when alone, or on a tie when port 0 was granted last.
    assign grantId = eligible[1] & (~eligible[0] | ~lastGrant);
`endif

    assign grantVec = {eligible[1] & grantId, eligible[0] & ~grantId};

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external 16-bit ALU between two requesters. Each port has a
// single response slot; a port is eligible only when its slot is free or is
// being drained this cycle. Undefined ops are answered locally with rspErr.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         reqValid,
    output logic [1:0]         reqReady,
    input  logic [2*WIDTH-1:0] reqA,
    input  logic [2*WIDTH-1:0] reqB,
    input  logic [5:0]         reqOp,
    output logic [1:0]         rspValid,
    input  logic [1:0]         rspReady,
    output logic [2*WIDTH-1:0] rspResult,
    output logic [1:0]         rspZero,
    output logic [1:0]         rspErr,
    output logic [WIDTH-1:0]   aluSrcA,
    output logic [WIDTH-1:0]   aluSrcB,
    output logic [2:0]         aluControl,
    input  logic [WIDTH-1:0]   aluResult,
    input  logic               aluZero
);

    logic [1:0]       eligible;
    logic [1:0]       grant_vec;
    logic             grant_id;
    logic             any_grant;
    logic             last_grant;
    logic [1:0]       slot_valid;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_ok;

    // Nothing is granted while reset is asserted, so the ALU idles too.
    assign eligible = reset ? 2'b00 : (reqValid & (~slot_valid | rspReady));

    alu_rr_pick u_pick (
        .eligible  (eligible),
        .lastGrant (last_grant),
        .grantVec  (grant_vec),
        .grantId   (grant_id)
    );

    assign any_grant = |grant_vec;
    assign reqReady  = grant_vec;

    assign sel_op = grant_id ? reqOp[5:3]             : reqOp[2:0];
    assign sel_a  = grant_id ? reqA[WIDTH +: WIDTH]   : reqA[0 +: WIDTH];
    assign sel_b  = grant_id ? reqB[WIDTH +: WIDTH]   : reqB[0 +: WIDTH];
    assign sel_ok = any_grant & aluOpValid(sel_op);

    // The ALU only sees a granted, defined op; otherwise it idles on 0 + 0.
    assign aluSrcA    = sel_ok ? sel_a  : '0;
    assign aluSrcB    = sel_ok ? sel_b  : '0;
    assign aluControl = sel_ok ? sel_op : ALU_IDLE_OP;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    logic last_grant_q;

    // Remember the most recent winner; reset value 1 lets port 0 take the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (any_grant) begin
            last_grant_q <= grant_id;
        end
    end

    assign last_grant = last_grant_q;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic             valid_q, valid_d;
            logic [WIDTH-1:0] result_q, result_d;
            logic             zero_q, zero_d;
            logic             err_q, err_d;

            // Load on grant (a load beats a same-cycle drain), else clear on drain.
            always_comb begin
                valid_d  = valid_q;
                result_d = result_q;
                zero_d   = zero_q;
                err_d    = err_q;
                if (grant_vec[gi]) begin
                    valid_d  = 1'b1;
                    result_d = sel_ok ? aluResult : '0;
                    zero_d   = sel_ok ? aluZero   : 1'b1;
                    err_d    = ~sel_ok;
                end else if (valid_q && rspReady[gi]) begin
                    valid_d = 1'b0;
                end
            end

            // Response slot register; an async reset discards any pending response.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q  <= 1'b0;
                    result_q <= '0;
                    zero_q   <= 1'b0;
                    err_q    <= 1'b0;
                end else begin
                    valid_q  <= valid_d;
                    result_q <= result_d;
                    zero_q   <= zero_d;
                    err_q    <= err_d;
                end
            end

            assign slot_valid[gi]               = valid_q;
            assign rspValid[gi]                 = valid_q;
            assign rspResult[gi*WIDTH +: WIDTH] = result_q;
            assign rspZero[gi]                  = zero_q;
            assign rspErr[gi]                   = err_q;
        end
    endgenerate

endmodule
